// File: rtl/grid_color_mapper.sv
// grid_color_mapper
//   Overlays a GRID_COLS x GRID_ROWS cell grid on the raster, highlights a
//   blinking cursor cell and merges a foreground glyph layer. Two-cycle
//   latency from DrawX/DrawY to Red/Green/Blue.
//
// Ports
//   pxl_clk                 pixel clock, all state on its rising edge
//   RESET                   asynchronous, active-low reset
//   blank                   1 = active video, 0 = blanking
//   act_pix                 foreground (glyph) pixel present
//   FGD_R/FGD_G/FGD_B       foreground colour
//   DrawX/DrawY             current pixel coordinate (DrawX steps by 1 per clock)
//   frame_start             one-cycle pulse at start of each frame
//   cursor_col/cursor_row   selected cell index
//   invert_mode             invert all visible output colours
//   cell_col/cell_row       cell index of the pixel (1-cycle latency)
//   in_cell                 pixel is inside a cell interior (1-cycle latency)
//   Red/Green/Blue          pixel colour (2-cycle latency)
module grid_color_mapper #(
    parameter int          GRID_X0      = 3,
    parameter int          GRID_Y0      = 80,
    parameter int          GRID_COLS    = 8,
    parameter int          GRID_ROWS    = 8,
    parameter int          CELL_W       = 48,
    parameter int          CELL_H       = 48,
    parameter int          LINE_W       = 2,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] HL_RGB       = 12'hFF0
) (
    input  logic       pxl_clk,
    input  logic       RESET,
    input  logic       blank,
    input  logic       act_pix,
    input  logic [3:0] FGD_R,
    input  logic [3:0] FGD_G,
    input  logic [3:0] FGD_B,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       frame_start,
    input  logic [7:0] cursor_col,
    input  logic [7:0] cursor_row,
    input  logic       invert_mode,
    output logic [7:0] cell_col,
    output logic [7:0] cell_row,
    output logic       in_cell,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue
);

    localparam int PITCH_X = CELL_W + LINE_W;
    localparam int PITCH_Y = CELL_H + LINE_W;

    localparam logic [10:0] X_LO   = 11'(GRID_X0);
    localparam logic [10:0] X_EDGE = 11'(GRID_X0 + GRID_COLS * PITCH_X);
    localparam logic [10:0] X_HI   = 11'(GRID_X0 + GRID_COLS * PITCH_X + LINE_W);
    localparam logic [10:0] Y_LO   = 11'(GRID_Y0);
    localparam logic [10:0] Y_EDGE = 11'(GRID_Y0 + GRID_ROWS * PITCH_Y);
    localparam logic [10:0] Y_HI   = 11'(GRID_Y0 + GRID_ROWS * PITCH_Y + LINE_W);

    localparam logic [9:0] PX_LAST    = 10'(PITCH_X - 1);
    localparam logic [9:0] PY_LAST    = 10'(PITCH_Y - 1);
    localparam logic [9:0] LW         = 10'(LINE_W);
    localparam logic [7:0] N_COLS     = 8'(GRID_COLS);
    localparam logic [7:0] N_ROWS     = 8'(GRID_ROWS);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // Priority: blanking, grid line, glyph, cursor highlight, white background.
    // Inversion applies to everything except blanked pixels.
    function automatic logic [11:0] shade(input logic vis, input logic line,
                                          input logic fg_on, input logic hit,
                                          input logic blink, input logic [11:0] fgd,
                                          input logic inv);
        logic [11:0] c;
        if (line)
            c = 12'h000;
        else if (fg_on)
            c = fgd;
        else if (hit && blink)
            c = HL_RGB;
        else
            c = 12'hFFF;
        if (!vis)
            return 12'h000;
        return inv ? ~c : c;
    endfunction

    // Offset/index trackers hold the values of the most recent pixel seen;
    // the *_nxt values are those of the current DrawX/DrawY.
    logic [9:0]  x_off, y_off, x_off_nxt, y_off_nxt;
    logic [7:0]  col_idx, row_idx, col_nxt, row_nxt;
    logic [10:0] px, py;
    logic        in_x, in_y, in_ext, line_c, cell_c, hit_c;

    assign px   = {1'b0, DrawX};
    assign py   = {1'b0, DrawY};
    assign in_x = (px >= X_LO) && (px < X_HI);
    assign in_y = (py >= Y_LO) && (py < Y_HI);

    always_comb begin
        x_off_nxt = x_off;
        col_nxt   = col_idx;
        if (px == X_LO) begin
            x_off_nxt = '0;
            col_nxt   = '0;
        end else if (in_x) begin
            if (x_off == PX_LAST) begin
                x_off_nxt = '0;
                col_nxt   = col_idx + 8'd1;
            end else begin
                x_off_nxt = x_off + 10'd1;
            end
        end

        // Rows advance once per line, on the DrawX==0 pixel.
        y_off_nxt = y_off;
        row_nxt   = row_idx;
        if (DrawX == 10'd0) begin
            if (py == Y_LO) begin
                y_off_nxt = '0;
                row_nxt   = '0;
            end else if (in_y) begin
                if (y_off == PY_LAST) begin
                    y_off_nxt = '0;
                    row_nxt   = row_idx + 8'd1;
                end else begin
                    y_off_nxt = y_off + 10'd1;
                end
            end
        end
    end

    // The closing right/bottom edge also reads as a short offset after the
    // final wrap; the explicit edge compare keeps it a line regardless.
    assign in_ext = in_x && in_y;
    assign line_c = in_ext && ((x_off_nxt < LW) || (y_off_nxt < LW) ||
                               (px >= X_EDGE) || (py >= Y_EDGE));
    assign cell_c = in_ext && !line_c;
    assign hit_c  = cell_c && (cursor_col < N_COLS) && (cursor_row < N_ROWS) &&
                    (col_nxt == cursor_col) && (row_nxt == cursor_row);

    always_ff @(posedge pxl_clk or negedge RESET) begin
        if (!RESET) begin
            x_off   <= '0;
            y_off   <= '0;
            col_idx <= '0;
            row_idx <= '0;
        end else begin
            x_off   <= x_off_nxt;
            y_off   <= y_off_nxt;
            col_idx <= col_nxt;
            row_idx <= row_nxt;
        end
    end

    // ---- stage 1: grid position, with pixel attributes aligned to it ----
    logic        line_p1, hit_p1, blank_p1, act_p1, inv_p1;
    logic [11:0] fgd_p1;

    always_ff @(posedge pxl_clk or negedge RESET) begin
        if (!RESET) begin
            line_p1  <= 1'b0;
            in_cell  <= 1'b0;
            cell_col <= '0;
            cell_row <= '0;
            hit_p1   <= 1'b0;
            blank_p1 <= 1'b0;
            act_p1   <= 1'b0;
            fgd_p1   <= '0;
            inv_p1   <= 1'b0;
        end else begin
            line_p1  <= line_c;
            in_cell  <= cell_c;
            cell_col <= in_ext ? col_nxt : 8'd0;
            cell_row <= in_ext ? row_nxt : 8'd0;
            hit_p1   <= hit_c;
            blank_p1 <= blank;
            act_p1   <= act_pix;
            fgd_p1   <= {FGD_R, FGD_G, FGD_B};
            inv_p1   <= invert_mode;
        end
    end

    // Cursor blink: phase flips every BLINK_FRAMES frame_start pulses.
    logic [7:0] frame_cnt;
    logic       blink_on;

    always_ff @(posedge pxl_clk or negedge RESET) begin
        if (!RESET) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // ---- stage 2: colour output ----
    always_ff @(posedge pxl_clk or negedge RESET) begin
        if (!RESET) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else begin
            {Red, Green, Blue} <= shade(blank_p1, line_p1, act_p1, hit_p1,
                                        blink_on, fgd_p1, inv_p1);
        end
    end

endmodule
